// File: rtl/mips_muldiv.sv
// Unsigned MULTU/DIVU unit: 32-step iterative shift-add multiply and restoring divide.
// Optional macro MULDIV_FAST_MUL_EN swaps the iterative MULTU for a one-cycle product.
module mips_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  AluOP,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [3:0]    OP_MULTU  = 4'd3;
    localparam logic [3:0]    OP_DIVU   = 4'd4;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic [W-1:0]    opnd;
    logic [2*W-1:0]  acc;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_trial;
    logic [W:0]      div_diff;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  step_next;
    logic            finish_now;
    logic            accept;

    // One datapath step: acc holds {partial_hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc[W-1:1]};
        div_trial = acc[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, opnd};
        if (div_trial >= {1'b0, opnd}) begin
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            div_next = {div_trial[W-1:0], acc[W-2:0], 1'b0};
        end
        step_next  = is_div ? div_next : mul_next;
        finish_now = (cnt == LAST_STEP);
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) begin
            step_next  = (2*W)'(opnd) * (2*W)'(acc[W-1:0]);
            finish_now = 1'b1;
        end
`endif
        accept = (state == IDLE) && start && ((AluOP == OP_MULTU) || (AluOP == OP_DIVU));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= (AluOP == OP_DIVU);
                        opnd   <= (AluOP == OP_DIVU) ? Y : X;
                        acc    <= {{W{1'b0}}, ((AluOP == OP_DIVU) ? X : Y)};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt + CW'(1);
                    // Results become visible only on the final step
                    if (finish_now) begin
                        HI    <= step_next[2*W-1:W];
                        LO    <= step_next[W-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high. Ports are listed below, clock and reset first.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe, sampled on the rising edge.
REQ-005 AluOP  input  4  operation code using the ALU encoding: 3 = MULTU, 4 = DIVU; all other codes are not operations for this block.
REQ-006 X  input  32  multiplicand or dividend (unsigned).
REQ-007 Y  input  32  multiplier or divisor (unsigned).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when a result has been written to HI/LO.
REQ-010 HI  output  32  MULTU: product[63:32]; DIVU: remainder.
REQ-011 LO  output  32  MULTU: product[31:0]; DIVU: quotient.

Function
REQ-012 The FSM SHALL have two states, IDLE and RUN, plus a registered 6-bit step counter.
REQ-013 An operation SHALL be accepted at a rising edge only when state=IDLE, start=1 and AluOP is 3 or 4; at that edge X, Y and op are latched, the counter is cleared, the state moves to RUN and busy goes to 1.
REQ-014 When start=1 with any other AluOP, or with state=RUN, the block SHALL ignore the request; there is no queueing and the in-flight operation is unaffected.
REQ-015 MULTU (iterative): one shift-add step per cycle in RUN over 32 steps, producing a 64-bit unsigned product with no truncation.
REQ-016 DIVU: one restoring-division step per cycle in RUN over 32 steps, producing a 32-bit quotient and a 32-bit remainder.
REQ-017 Divide by zero SHALL take no special path; natural restoring behaviour gives LO=32'hFFFFFFFF and HI=X, with the normal latency.
REQ-018 At the edge that completes step 32, the block SHALL write HI/LO, set the state to IDLE, set busy to 0 and set done to 1 for exactly one cycle.
REQ-019 Latency SHALL be exactly 32 cycles from the accepting edge to the first cycle with done=1; busy SHALL be high for exactly those 32 cycles.
REQ-020 A new start SHALL be accepted in the same cycle that done=1, because the state is already IDLE.
REQ-021 HI/LO SHALL hold their last result at all other times and SHALL NOT change during RUN.
REQ-022 X and Y SHALL be don't-care after the accepting edge, because operands are latched.

Reset
REQ-023 rst=1 at a rising edge SHALL force: state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0 and internal operands=0.
REQ-024 Reset during RUN SHALL abort the operation; no done pulse is produced and the partial result is discarded.
REQ-025 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-026 The macro MULDIV_FAST_MUL_EN SHALL select the MULTU implementation.
REQ-027 With MULDIV_FAST_MUL_EN defined: MULTU uses a single-cycle 32x32 combinational product; busy is high for 1 cycle, and HI/LO are written and done pulses 1 cycle after the accepting edge.
REQ-028 Without MULDIV_FAST_MUL_EN: MULTU is iterative with 32-cycle latency, as in REQ-015.
REQ-029 DIVU timing and results SHALL be identical in both builds.

Verification
REQ-030 Basic multiply: MULTU X=7, Y=6 -> HI=0, LO=42; done exactly 32 cycles after the accepting edge (1 cycle with MULDIV_FAST_MUL_EN).
REQ-031 Maximum multiply: MULTU X=Y=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-032 Divide and zero divisor: DIVU X=100, Y=7 -> LO=14, HI=2 after 32 cycles; DIVU X=5, Y=0 -> LO=32'hFFFFFFFF, HI=5 after 32 cycles.
REQ-033 Ignored requests: DIVU 100/7 accepted, then MULTU 3*3 with start=1 at cycle 10 -> ignored, result 14/2 as before; start with AluOP=5 while IDLE -> busy stays 0, HI/LO unchanged.
REQ-034 Reset mid-operation: rst pulsed at cycle 15 of DIVU 100/7 -> busy=0 next cycle, no done pulse, HI=LO=0.
REQ-035 Back-to-back: start MULTU 2*3 in the done cycle of a prior DIVU -> accepted; LO=6 after 32 cycles; no idle gap is required.
